// File: rtl/sdram_ahb_tester_if.sv
// Request/response bus between the self-test engine and the sdram_controller slave port.
interface sdram_ahb_tester_if;
    logic        HSEL;
    logic        HWRITE;
    logic [31:0] HADDR;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;

    modport master (
        output HSEL,
        output HWRITE,
        output HADDR,
        output HWDATA,
        input  HREADY,
        input  HRDATA
    );

    modport slave (
        input  HSEL,
        input  HWRITE,
        input  HADDR,
        input  HWDATA,
        output HREADY,
        output HRDATA
    );
endinterface

// File: rtl/sdram_ahb_tester.sv
// SDRAM traffic engine: writes a patterned burst, reads it back and counts mismatches.
// Optional per-transfer HREADY watchdog enabled by defining SDRAM_TESTER_TIMEOUT_EN.
module sdram_ahb_tester #(
    parameter int unsigned ADDR_STEP   = 4,
    parameter int unsigned ERR_W       = 8,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic                 in_HCLK,
    input  logic                 in_HRESET,
    input  logic                 in_start,
    input  logic [31:0]          in_base_addr,
    input  logic [7:0]           in_len,
    input  logic [31:0]          in_seed,
    sdram_ahb_tester_if.master   bus,
    output logic                 out_busy,
    output logic                 out_done,
    output logic [ERR_W-1:0]     out_err_cnt,
    output logic [31:0]          out_err_addr
`ifdef SDRAM_TESTER_TIMEOUT_EN
    ,
    output logic                 out_timeout
`endif
);

    typedef enum logic [2:0] {
        StIdle,
        StWrReq,
        StWrGap,
        StRdReq,
        StRdGap,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        base_q, base_d;
    logic [31:0]        seed_q, seed_d;
    logic [7:0]         len_q, len_d;
    logic [7:0]         idx_q, idx_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        data_q, data_d;
    logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
    logic [31:0]        err_addr_q, err_addr_d;
    logic               req;
    logic               last_word;

`ifdef SDRAM_TESTER_TIMEOUT_EN
    localparam int unsigned WaitW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT_CYC - 1);

    logic             timeout_q, timeout_d;
    logic [WaitW-1:0] wait_q, wait_d;
`endif

    assign req       = (state_q == StWrReq) || (state_q == StRdReq);
    assign last_word = ((idx_q + 8'd1) == len_q);

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        seed_d     = seed_q;
        len_d      = len_q;
        idx_d      = idx_q;
        addr_d     = addr_q;
        data_d     = data_q;
        err_cnt_d  = err_cnt_q;
        err_addr_d = err_addr_q;
`ifdef SDRAM_TESTER_TIMEOUT_EN
        timeout_d  = timeout_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (in_start) begin
                    base_d     = in_base_addr;
                    seed_d     = in_seed;
                    len_d      = in_len;
                    idx_d      = '0;
                    addr_d     = in_base_addr;
                    data_d     = in_seed;
                    err_cnt_d  = '0;
                    err_addr_d = '0;
`ifdef SDRAM_TESTER_TIMEOUT_EN
                    timeout_d  = 1'b0;
`endif
                    state_d    = (in_len == 8'd0) ? StDone : StWrReq;
                end
            end
            StWrReq: begin
                if (bus.HREADY) state_d = StWrGap;
            end
            StWrGap: begin
                if (last_word) begin
                    idx_d   = '0;
                    addr_d  = base_q;
                    data_d  = seed_q;
                    state_d = StRdReq;
                end else begin
                    idx_d   = idx_q + 8'd1;
                    addr_d  = addr_q + 32'(ADDR_STEP);
                    data_d  = data_q + 32'd1;
                    state_d = StWrReq;
                end
            end
            StRdReq: begin
                if (bus.HREADY) begin
                    // A zero count means no earlier mismatch, so this one owns err_addr.
                    if (bus.HRDATA != data_q) begin
                        if (err_cnt_q == '0) err_addr_d = addr_q;
                        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_W'(1);
                    end
                    state_d = StRdGap;
                end
            end
            StRdGap: begin
                if (last_word) begin
                    state_d = StDone;
                end else begin
                    idx_d   = idx_q + 8'd1;
                    addr_d  = addr_q + 32'(ADDR_STEP);
                    data_d  = data_q + 32'd1;
                    state_d = StRdReq;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

`ifdef SDRAM_TESTER_TIMEOUT_EN
        // Counter only runs inside a request, so every HSEL rise starts from zero.
        wait_d = '0;
        if (req && !bus.HREADY) begin
            if (wait_q == WaitLast) begin
                timeout_d = 1'b1;
                state_d   = StDone;
            end else begin
                wait_d = wait_q + WaitW'(1);
            end
        end
`endif
    end

    always_ff @(posedge in_HCLK or negedge in_HRESET) begin
        if (!in_HRESET) begin
            state_q    <= StIdle;
            base_q     <= '0;
            seed_q     <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            err_cnt_q  <= '0;
            err_addr_q <= '0;
`ifdef SDRAM_TESTER_TIMEOUT_EN
            timeout_q  <= 1'b0;
            wait_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            seed_q     <= seed_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            err_cnt_q  <= err_cnt_d;
            err_addr_q <= err_addr_d;
`ifdef SDRAM_TESTER_TIMEOUT_EN
            timeout_q  <= timeout_d;
            wait_q     <= wait_d;
`endif
        end
    end

    // Bus outputs decode the state register so an async reset drops HSEL at once.
    assign bus.HSEL     = req;
    assign bus.HWRITE   = (state_q == StWrReq);
    assign bus.HADDR    = req ? addr_q : 32'd0;
    assign bus.HWDATA   = (state_q == StWrReq) ? data_q : 32'd0;
    assign out_busy     = req || (state_q == StWrGap) || (state_q == StRdGap);
    assign out_done     = (state_q == StDone);
    assign out_err_cnt  = err_cnt_q;
    assign out_err_addr = err_addr_q;
`ifdef SDRAM_TESTER_TIMEOUT_EN
    assign out_timeout  = timeout_q;
`endif

endmodule

// File: tb/tb_sdram_ahb_tester.sv
// Directed bench for sdram_ahb_tester: memory-backed slave with stall, corruption and stuck modes.
module tb_sdram_ahb_tester;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base = '0;
    logic [31:0] seed = '0;
    logic [7:0]  len = '0;
    logic        busy;
    logic        done;
    logic [7:0]  err_cnt;
    logic [31:0] err_addr;
`ifdef SDRAM_TESTER_TIMEOUT_EN
    logic        timeout;
`endif

    sdram_ahb_tester_if bus ();

    sdram_ahb_tester #(
        .ADDR_STEP   (4),
        .ERR_W       (8),
        .TIMEOUT_CYC (64)
    ) dut (
        .in_HCLK      (clk),
        .in_HRESET    (rst_n),
        .in_start     (start),
        .in_base_addr (base),
        .in_len       (len),
        .in_seed      (seed),
        .bus          (bus.master),
        .out_busy     (busy),
        .out_done     (done),
        .out_err_cnt  (err_cnt),
        .out_err_addr (err_addr)
`ifdef SDRAM_TESTER_TIMEOUT_EN
        ,
        .out_timeout  (timeout)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Slave controls, written only by the main thread.
    logic [31:0] bad_a = 32'h1;
    logic [31:0] bad_b = 32'h1;
    logic [31:0] stall_addr = 32'h1;
    bit          stuck = 1'b0;

    logic [31:0] mem [logic [31:0]];
    logic [31:0] log_addr [$];
    logic [31:0] log_data [$];
    logic        log_we [$];
    int          done_cnt = 0;
    int          hsel_cycles = 0;

    always @(posedge clk) begin
        if (done) done_cnt++;
        if (bus.HSEL) hsel_cycles++;
        if (bus.HSEL && bus.HREADY) begin
            log_addr.push_back(bus.HADDR);
            log_we.push_back(bus.HWRITE);
            log_data.push_back(bus.HWRITE ? bus.HWDATA : bus.HRDATA);
            if (bus.HWRITE) mem[bus.HADDR] = bus.HWDATA;
        end
    end

    initial begin : slave
        bit prev_hsel;
        int stall_left;
        logic [31:0] rd;
        prev_hsel  = 1'b0;
        stall_left = 0;
        bus.HREADY = 1'b1;
        bus.HRDATA = '0;
        forever begin
            @(negedge clk);
            if (stuck) begin
                bus.HREADY = 1'b0;
            end else if (bus.HSEL) begin
                if (!prev_hsel && bus.HWRITE && bus.HADDR == stall_addr) stall_left = 5;
                if (stall_left > 0) begin
                    bus.HREADY = 1'b0;
                    stall_left--;
                end else begin
                    rd = mem.exists(bus.HADDR) ? mem[bus.HADDR] : 32'd0;
                    if (bus.HADDR == bad_a || bus.HADDR == bad_b) rd = rd ^ 32'h0000_0001;
                    bus.HREADY = 1'b1;
                    bus.HRDATA = rd;
                end
            end else begin
                // Ready high while idle must be ignored by the DUT.
                bus.HREADY = 1'b1;
                bus.HRDATA = 32'hDEAD_BEEF;
            end
            prev_hsel = bus.HSEL;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic kick(input logic [31:0] b, input logic [7:0] l, input logic [31:0] s);
        base  = b;
        len   = l;
        seed  = s;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(inout int edges);
        while (!done && edges < 2000) begin
            tick();
            edges++;
        end
        check("done_seen", done, 1'b1);
    endtask

    // Compare the transfer log from index lb against n writes then n reads of the pattern.
    task automatic check_burst(input string tag, input int lb, input logic [31:0] b,
                               input int n, input logic [31:0] s);
        check({tag, "_log_len"}, log_addr.size() - lb, 2 * n);
        for (int i = 0; i < 2 * n && lb + i < log_addr.size(); i++) begin
            check({tag, "_addr"}, log_addr[lb+i], b + 32'((i % n) * 4));
            check({tag, "_we"}, log_we[lb+i], (i < n) ? 1'b1 : 1'b0);
            if (i < n) check({tag, "_wdata"}, log_data[lb+i], s + 32'(i));
        end
    endtask

    initial begin : main
        int edges;
        int lb;
        int d0;
        int h0;

        tick();
        tick();
        check("rst_hsel", bus.HSEL, 1'b0);
        check("rst_haddr", bus.HADDR, 32'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err_cnt", err_cnt, 8'd0);
        check("rst_err_addr", err_addr, 32'd0);
        rst_n = 1'b1;
        tick();

        // Clean burst, ideal slave.
        lb = log_addr.size(); d0 = done_cnt; edges = 1;
        kick(32'h100, 8'd4, 32'hA5A5_0000);
        check("a_busy", busy, 1'b1);
        wait_done(edges);
        check("a_latency", edges, 17);
        check("a_busy_at_done", busy, 1'b0);
        tick(); tick();
        check_burst("a", lb, 32'h100, 4, 32'hA5A5_0000);
        check("a_done_pulses", done_cnt - d0, 1);
        check("a_err_cnt", err_cnt, 8'd0);
        check("a_err_addr", err_addr, 32'd0);

        // Single corrupted read.
        bad_a = 32'h108;
        edges = 1;
        kick(32'h100, 8'd4, 32'hA5A5_0000);
        wait_done(edges);
        tick(); tick(); tick();
        check("b_err_cnt", err_cnt, 8'd1);
        check("b_err_addr", err_addr, 32'h108);

        // Two mismatches: address of the first one is kept.
        bad_a = 32'h104; bad_b = 32'h10C;
        edges = 1;
        kick(32'h100, 8'd4, 32'hA5A5_0000);
        wait_done(edges);
        check("c_err_cnt", err_cnt, 8'd2);
        check("c_err_addr", err_addr, 32'h104);
        bad_a = 32'h1; bad_b = 32'h1;
        tick();

        // len=0: no bus traffic; done shows in the cycle after the start cycle.
        h0 = hsel_cycles; d0 = done_cnt; edges = 1;
        kick(32'h500, 8'd0, 32'h0);
        wait_done(edges);
        check("z_latency", edges, 1);
        check("z_err_cleared", err_cnt, 8'd0);
        tick(); tick();
        check("z_no_hsel", hsel_cycles - h0, 0);
        check("z_done_pulses", done_cnt - d0, 1);

        // Address and data wrap around 2^32.
        lb = log_addr.size(); edges = 1;
        kick(32'hFFFF_FFF8, 8'd3, 32'hFFFF_FFFE);
        wait_done(edges);
        check("w_latency", edges, 13);
        check_burst("w", lb, 32'hFFFF_FFF8, 3, 32'hFFFF_FFFE);
        check("w_err_cnt", err_cnt, 8'd0);
        tick();

        // Five-cycle stall on write of word 1; start pulses inside the stall are ignored.
        stall_addr = 32'h204;
        lb = log_addr.size(); edges = 1;
        kick(32'h200, 8'd3, 32'h1234_0000);
        while (!(bus.HSEL && bus.HADDR == 32'h204) && edges < 50) begin
            tick();
            edges++;
        end
        for (int k = 0; k < 5; k++) begin
            check("s_hsel", bus.HSEL, 1'b1);
            check("s_haddr", bus.HADDR, 32'h204);
            check("s_hwdata", bus.HWDATA, 32'h1234_0001);
            if (k == 1) begin
                base = 32'h900; len = 8'd1; start = 1'b1;
            end
            if (k == 2) start = 1'b0;
            tick();
            edges++;
        end
        wait_done(edges);
        check("s_latency", edges, 18);
        // Start coincident with done must be ignored too.
        start = 1'b1;
        tick();
        start = 1'b0;
        check("s_busy_after_done_start", busy, 1'b0);
        tick();
        check("s_still_idle", bus.HSEL, 1'b0);
        check_burst("s", lb, 32'h200, 3, 32'h1234_0000);
        stall_addr = 32'h1;

        // Asynchronous reset during the read phase.
        d0 = done_cnt; edges = 0;
        kick(32'h300, 8'd4, 32'h5555_0000);
        while (!(bus.HSEL && !bus.HWRITE) && edges < 100) begin
            tick();
            edges++;
        end
        check("r_in_read", bus.HSEL, 1'b1);
        rst_n = 1'b0;
        #1;
        check("r_hsel_drop", bus.HSEL, 1'b0);
        check("r_busy_drop", busy, 1'b0);
        tick(); tick();
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        check("r_no_done", done_cnt - d0, 0);
        check("r_idle", busy, 1'b0);

`ifdef SDRAM_TESTER_TIMEOUT_EN
        // HREADY stuck low: watchdog ends the test after 64 request cycles.
        stuck = 1'b1;
        lb = log_addr.size(); edges = 1;
        kick(32'h400, 8'd2, 32'h0);
        wait_done(edges);
        check("t_latency", edges, 65);
        check("t_timeout", timeout, 1'b1);
        check("t_no_xfer", log_addr.size() - lb, 0);
        stuck = 1'b0;
        tick();
        edges = 1;
        kick(32'h400, 8'd1, 32'h7);
        wait_done(edges);
        check("t_cleared", timeout, 1'b0);
        check("t_latency2", edges, 5);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
